tdc_therm_capture: RTL and testbench

//  Reader for the carry-chain delay line: samples the LENGTH raw tap outputs, detects a hit,

---
 rtl/tdc_pkg.sv | 15 +
 rtl/tdc_popcount.sv | 55 +++++
 rtl/tdc_therm_capture.sv | 139 +++++++++++++
 tb/tb_tdc_therm_capture.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared types and helpers for the delay-line thermometer capture block.
package tdc_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, CONV, HOLD} tdc_state_t;

  localparam int unsigned TDC_CONV_CYCLES = 2;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/tdc_popcount.sv
// Two-stage pipelined ones count: 16-bit slice totals, then a sum of the slice totals.
module tdc_popcount
  import tdc_pkg::*;
#(
  parameter int unsigned LENGTH = 128
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [LENGTH-1:0]           din,
  output logic [clog2(LENGTH+1)-1:0]  dout
);

  localparam int unsigned SLICE_W = 16;
  localparam int unsigned NSLICE  = (LENGTH + SLICE_W - 1) / SLICE_W;
  localparam int unsigned PAD_W   = NSLICE * SLICE_W;
  localparam int unsigned CNT_W   = clog2(LENGTH + 1);

  logic [PAD_W-1:0] din_pad;
  logic [4:0]       slice_d [NSLICE];
  logic [4:0]       slice_q [NSLICE];
  logic [CNT_W-1:0] sum_d;
  logic [CNT_W-1:0] dout_q;

  // Zero padding keeps the last slice harmless when LENGTH is not a multiple of 16.
  assign din_pad = PAD_W'(din);

  always_comb begin
    for (int s = 0; s < NSLICE; s++) begin
      slice_d[s] = '0;
      for (int b = 0; b < SLICE_W; b++) begin
        slice_d[s] = slice_d[s] + 5'(din_pad[s*SLICE_W+b]);
      end
    end
  end

  always_comb begin
    sum_d = '0;
    for (int s = 0; s < NSLICE; s++) begin
      sum_d = sum_d + CNT_W'(slice_q[s]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NSLICE; s++) slice_q[s] <= '0;
      dout_q <= '0;
    end else begin
      for (int s = 0; s < NSLICE; s++) slice_q[s] <= slice_d[s];
      dout_q <= sum_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/tdc_therm_capture.sv
// Carry-chain delay-line reader: synchronises the taps, detects a hit, converts the
// thermometer sample to a bubble-tolerant zero count and pairs it with a coarse timestamp.
module tdc_therm_capture
  import tdc_pkg::*;
#(
  parameter int unsigned LENGTH   = 128,
  parameter int unsigned FINE_W   = 8,
  parameter int unsigned COARSE_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LENGTH-1:0]   therm_in,
  input  logic                arm,
  output logic                hit_valid,
  input  logic                hit_ready,
  output logic [FINE_W-1:0]   hit_fine,
  output logic [COARSE_W-1:0] hit_coarse,
  output logic                hit_sat,
  output logic                missed,
  output logic                busy
);

  localparam int unsigned CNT_W = clog2(LENGTH + 1);

  tdc_state_t          state_q, state_d;
  logic [1:0]          conv_cnt_q, conv_cnt_d;
  logic [LENGTH-1:0]   s0_q, s1_q;
  logic                s1_prev_q;
  logic [COARSE_W-1:0] coarse_q, c0_q, c1_q;
  logic                hit_valid_q, hit_valid_d;
  logic [FINE_W-1:0]   hit_fine_q, hit_fine_d;
  logic [COARSE_W-1:0] hit_coarse_q, hit_coarse_d;
  logic                hit_sat_q, hit_sat_d;
  logic                missed_q, missed_d;
  logic [CNT_W-1:0]    ones_cnt;
  logic [CNT_W-1:0]    zero_cnt;
  logic                hit_edge;

  assign hit_edge = ~s1_q[0] & s1_prev_q;

  // Stage 1 captures s1 on the same edge the FSM latches the hit, so the count of the
  // latched sample is ready after exactly TDC_CONV_CYCLES edges.
  tdc_popcount #(
    .LENGTH(LENGTH)
  ) u_popcount (
    .clk (clk),
    .rst (rst),
    .din (s1_q),
    .dout(ones_cnt)
  );

  assign zero_cnt = CNT_W'(LENGTH) - ones_cnt;

  always_comb begin
    state_d      = state_q;
    conv_cnt_d   = conv_cnt_q;
    hit_valid_d  = hit_valid_q;
    hit_fine_d   = hit_fine_q;
    hit_coarse_d = hit_coarse_q;
    hit_sat_d    = hit_sat_q;
    missed_d     = missed_q;
    unique case (state_q)
      IDLE: begin
        if (arm) begin
          state_d  = ARMED;
          missed_d = hit_edge;
        end else if (hit_edge) begin
          missed_d = 1'b1;
        end
      end
      ARMED: begin
        if (hit_edge) begin
          state_d      = CONV;
          conv_cnt_d   = '0;
          hit_coarse_d = c1_q;
        end
      end
      CONV: begin
        if (hit_edge) missed_d = 1'b1;
        if (conv_cnt_q == 2'(TDC_CONV_CYCLES - 1)) begin
          state_d     = HOLD;
          hit_valid_d = 1'b1;
          hit_fine_d  = FINE_W'(zero_cnt);
          hit_sat_d   = (ones_cnt == '0);
        end else begin
          conv_cnt_d = conv_cnt_q + 2'd1;
        end
      end
      HOLD: begin
        if (hit_edge) missed_d = 1'b1;
        if (hit_ready) begin
          state_d     = IDLE;
          hit_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      conv_cnt_q   <= '0;
      s0_q         <= '1;
      s1_q         <= '1;
      s1_prev_q    <= 1'b1;
      coarse_q     <= '0;
      c0_q         <= '0;
      c1_q         <= '0;
      hit_valid_q  <= 1'b0;
      hit_fine_q   <= '0;
      hit_coarse_q <= '0;
      hit_sat_q    <= 1'b0;
      missed_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      conv_cnt_q   <= conv_cnt_d;
      s0_q         <= therm_in;
      s1_q         <= s0_q;
      s1_prev_q    <= s1_q[0];
      coarse_q     <= coarse_q + COARSE_W'(1);
      c0_q         <= coarse_q;
      c1_q         <= c0_q;
      hit_valid_q  <= hit_valid_d;
      hit_fine_q   <= hit_fine_d;
      hit_coarse_q <= hit_coarse_d;
      hit_sat_q    <= hit_sat_d;
      missed_q     <= missed_d;
    end
  end

  assign hit_valid  = hit_valid_q;
  assign hit_fine   = hit_fine_q;
  assign hit_coarse = hit_coarse_q;
  assign hit_sat    = hit_sat_q;
  assign missed     = missed_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_tdc_therm_capture.sv
// Directed bench for tdc_therm_capture with a sample-history reference model.
module tb_tdc_therm_capture;

  localparam logic [127:0] ONES = '1;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] therm_in;
  logic         arm;
  logic         hit_valid;
  logic         hit_ready;
  logic [7:0]   hit_fine;
  logic [15:0]  hit_coarse;
  logic         hit_sat;
  logic         missed;
  logic         busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  tdc_therm_capture #(
    .LENGTH  (128),
    .FINE_W  (8),
    .COARSE_W(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .therm_in  (therm_in),
    .arm       (arm),
    .hit_valid (hit_valid),
    .hit_ready (hit_ready),
    .hit_fine  (hit_fine),
    .hit_coarse(hit_coarse),
    .hit_sat   (hit_sat),
    .missed    (missed),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: history of tap samples and their coarse stamps, plus transaction flags.
  logic [127:0] hs [3];
  logic [15:0]  hc [2];
  int unsigned  edge_cnt;
  bit           m_armed, m_pending, m_have, m_missed;
  int unsigned  m_due;
  int           m_fine;
  logic [15:0]  m_coarse;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        hs[0] = ONES; hs[1] = ONES; hs[2] = ONES;
        hc[0] = '0; hc[1] = '0;
        edge_cnt = 0;
        m_armed = 0; m_pending = 0; m_have = 0; m_missed = 0;
      end else begin
        automatic bit hit = !hs[1][0] && hs[2][0];
        if (m_have) begin
          if (hit) m_missed = 1;
          if (hit_ready) m_have = 0;
        end else if (m_pending) begin
          if (hit) m_missed = 1;
          if (edge_cnt == m_due) begin
            m_pending = 0;
            m_have    = 1;
          end
        end else if (m_armed) begin
          if (hit) begin
            m_armed   = 0;
            m_pending = 1;
            m_due     = edge_cnt + 2;
            m_fine    = 128 - $countones(hs[1]);
            m_coarse  = hc[1];
          end
        end else if (arm) begin
          m_armed  = 1;
          m_missed = hit;
        end else if (hit) begin
          m_missed = 1;
        end
        hs[2] = hs[1]; hs[1] = hs[0]; hs[0] = therm_in;
        hc[1] = hc[0]; hc[0] = 16'(edge_cnt);
        edge_cnt++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("cyc_valid", 32'(hit_valid), 32'(m_have));
      check("cyc_busy", 32'(busy), 32'(m_armed | m_pending | m_have));
      check("cyc_missed", 32'(missed), 32'(m_missed));
      if (m_have) begin
        check("cyc_fine", 32'(hit_fine), 32'(m_fine));
        check("cyc_coarse", 32'(hit_coarse), 32'(m_coarse));
        check("cyc_sat", 32'(hit_sat), 32'(m_fine == 128));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic goto_coarse(input logic [15:0] c);
    while (16'(edge_cnt) != c) @(negedge clk);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!hit_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("valid_seen", 32'(hit_valid), 32'd1);
  endtask

  task automatic accept();
    hit_ready = 1'b1;
    @(negedge clk);
    hit_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; therm_in = ONES; arm = 1'b0; hit_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: idle line, stray ready
    hit_ready = 1'b1;
    cyc(4);
    hit_ready = 1'b0;
    cyc(6);
    check("t1_valid", 32'(hit_valid), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_missed", 32'(missed), 32'd0);

    // 2: 8 zeros sampled at coarse 0x40
    goto_coarse(16'h003c);
    pulse_arm();
    goto_coarse(16'h0040);
    therm_in = {{120{1'b1}}, 8'h00};
    wait_valid();
    check("t2_latency", edge_cnt, 32'd69);
    check("t2_fine", 32'(hit_fine), 32'd8);
    check("t2_coarse", 32'(hit_coarse), 32'h40);
    check("t2_sat", 32'(hit_sat), 32'd0);
    accept();
    therm_in = ONES;
    cyc(3);
    check("t2_idle", 32'(busy), 32'd0);

    // 3: bubble, held result
    pulse_arm();
    cyc(2);
    therm_in = {{108{1'b1}}, 20'h00400};
    wait_valid();
    check("t3_fine", 32'(hit_fine), 32'd19);
    cyc(10);
    check("t3_hold_valid", 32'(hit_valid), 32'd1);
    check("t3_hold_fine", 32'(hit_fine), 32'd19);
    accept();
    check("t3_idle", 32'(busy), 32'd0);
    therm_in = ONES;
    cyc(3);

    // 4: saturated sample, hit during HOLD
    pulse_arm();
    cyc(2);
    therm_in = '0;
    wait_valid();
    check("t4_fine", 32'(hit_fine), 32'd128);
    check("t4_sat", 32'(hit_sat), 32'd1);
    therm_in = ONES;
    cyc(2);
    therm_in = '0;
    cyc(4);
    check("t4_missed", 32'(missed), 32'd1);
    check("t4_still_valid", 32'(hit_valid), 32'd1);
    accept();
    therm_in = ONES;
    cyc(3);
    pulse_arm();
    check("t4_missed_clr", 32'(missed), 32'd0);
    check("t4_armed", 32'(busy), 32'd1);

    // 5: coarse wrap between sample and readout
    goto_coarse(16'hffff);
    therm_in = {{124{1'b1}}, 4'h0};
    wait_valid();
    check("t5_coarse", 32'(hit_coarse), 32'hffff);
    check("t5_fine", 32'(hit_fine), 32'd4);
    accept();
    therm_in = ONES;
    cyc(3);
    // arm lands on the same edge the hit edge is seen
    therm_in = '0;
    cyc(2);
    pulse_arm();
    check("t5_same_missed", 32'(missed), 32'd1);
    check("t5_same_armed", 32'(busy), 32'd1);
    cyc(5);
    check("t5_no_capture", 32'(hit_valid), 32'd0);
    therm_in = ONES;
    cyc(3);

    // 6: reset mid-CONV, then a fresh capture
    therm_in = {{125{1'b1}}, 3'b000};
    cyc(3);
    check("t6_conv_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_valid", 32'(hit_valid), 32'd0);
    therm_in = ONES;
    @(negedge clk);
    rst = 1'b0;
    goto_coarse(16'h0004);
    pulse_arm();
    goto_coarse(16'h0010);
    therm_in = {{123{1'b1}}, 5'b00000};
    wait_valid();
    check("t6_fine", 32'(hit_fine), 32'd5);
    check("t6_coarse", 32'(hit_coarse), 32'h10);
    #2 rst = 1'b1;
    #1;
    check("t6_hold_rst_valid", 32'(hit_valid), 32'd0);
    therm_in = ONES;
    @(negedge clk);
    rst = 1'b0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
